// File: rtl/uart_tx_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_queue_if
//  Description : Bundle of the host-write, status and transmitter-handshake
//                signals of uart_tx_queue.
//                master : host / transmitter side (drives wr_en, wr_data,
//                         donetx; observes everything else)
//                slave  : the queue itself
//  Parameters  : DEPTH - FIFO depth in bytes; sets the width of count
//  Signals     : wr_en, wr_data[7:0], full, empty, count[AW:0], overflow,
//                dintx[7:0], newdata, donetx, busy
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    dintx;
    logic          newdata;
    logic          donetx;
    logic          busy;

    modport master (
        output wr_en, wr_data, donetx,
        input  full, empty, count, overflow, dintx, newdata, busy
    );

    modport slave (
        input  wr_en, wr_data, donetx,
        output full, empty, count, overflow, dintx, newdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_queue
//  Description : Byte FIFO plus launch sequencer placed in front of a UART
//                transmitter. Host bytes are buffered; one byte at a time is
//                presented on dintx with a one-cycle newdata strobe, and the
//                next launch waits for the transmitter's donetx pulse.
//  Config macro: UART_TXQ_GAP_EN - when defined, a GAP state inserts
//                GAP_CYCLES idle clocks after every donetx.
//  Ports       : clk, rst (sync, active-high)
//                bus (uart_tx_queue_if.slave):
//                  wr_en/wr_data  host write strobe and byte
//                  full/empty/count/overflow  FIFO status (overflow sticky)
//                  dintx/newdata  byte and launch strobe to the transmitter
//                  donetx         transmitter completion pulse
//                  busy           sequencer not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 104
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_tx_queue_if.slave    bus
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    C_DEPTH = (AW + 1)'(DEPTH);

    // Elaboration-time guard on the parameter ranges the logic relies on.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1) begin : g_param_check
        $error("uart_tx_queue: DEPTH must be a power of two >= 2 and GAP_CYCLES >= 1");
    end

`ifdef UART_TXQ_GAP_EN
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_GAP       = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          overflow_q;

    state_t        state_q;
    logic [7:0]    dintx_q;
    logic          newdata_q;
`ifdef UART_TXQ_GAP_EN
    logic [GW-1:0] gap_cnt_q;
`endif

    logic          w_full;
    logic          w_wr_accept;
    logic          w_pop;

    assign w_full = (count_q == C_DEPTH);

    always_comb begin
        // Full check is on the pre-edge count, so a write while full is
        // dropped even if a pop frees a slot at the same edge.
        w_wr_accept = bus.wr_en && !w_full;
        w_pop       = (state_q == ST_IDLE) && (count_q != '0);
        count_d     = count_q;
        case ({w_wr_accept, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (w_wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (bus.wr_en && w_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Contents need no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Launch sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= '0;
            dintx_q   <= 8'h00;
            newdata_q <= 1'b0;
`ifdef UART_TXQ_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            newdata_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_pop) begin
                        dintx_q   <= mem_q[rd_ptr_q];
                        newdata_q <= 1'b1;
                        rd_ptr_q  <= rd_ptr_q + 1'b1;
                        state_q   <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // dintx_q is left untouched so the transmitter sees a
                    // stable byte for the whole frame.
                    if (bus.donetx) begin
`ifdef UART_TXQ_GAP_EN
                        gap_cnt_q <= GW'(GAP_CYCLES - 1);
                        state_q   <= ST_GAP;
`else
                        state_q   <= ST_IDLE;
`endif
                    end
                end
`ifdef UART_TXQ_GAP_EN
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registers or decodes of registers only
    // ------------------------------------------------------------------
    assign bus.full     = w_full;
    assign bus.empty    = (count_q == '0);
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.dintx    = dintx_q;
    assign bus.newdata  = newdata_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_queue
//  Description : Self-checking bench for uart_tx_queue. A per-cycle vector
//                table covers launch latency, strobe width, spurious donetx
//                and turnaround; hand-written sequences cover burst ordering,
//                overflow, mid-byte reset and the byte-to-byte gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    localparam int DEPTH  = 16;
    localparam int GAP    = 104;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int TX_LAT = 10;
`ifdef UART_TXQ_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done_man = 1'b0;
    logic done_auto = 1'b0;
    logic tx_auto = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

    assign bus.donetx = done_man | done_auto;

    uart_tx_queue #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Launch monitor: records every launched byte and flags wide strobes
    // ------------------------------------------------------------------
    logic [7:0] cap[$];
    logic       nd_prev = 1'b0;
    int         nd_double = 0;

    always @(negedge clk) begin
        if (bus.newdata) cap.push_back(bus.dintx);
        if (bus.newdata && nd_prev) nd_double++;
        nd_prev = bus.newdata;
    end

    // Transmitter stand-in: answers each launch with donetx after TX_LAT clocks
    initial begin
        forever begin
            @(negedge clk);
            if (tx_auto && bus.newdata) begin
                repeat (TX_LAT) @(negedge clk);
                done_auto = 1'b1;
                @(negedge clk);
                done_auto = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] outs();
        return {bus.count, bus.full, bus.empty, bus.overflow, bus.newdata, bus.dintx, bus.busy};
    endfunction

    // Drive inputs at the falling edge, then sample 1 time unit after rise
    task automatic apply(input logic we, input logic [7:0] d, input logic dn);
        @(negedge clk);
        bus.wr_en   = we;
        bus.wr_data = d;
        done_man    = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        done_man    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait until nbytes launched since base and sequencer back to idle
    task automatic wait_drain(input string name, input int base, input int nbytes, input int budget);
        int  t;
        bit  ok;
        ok = 1'b0;
        for (t = 0; t < budget; t++) begin
            @(posedge clk);
            #1;
            if ((cap.size() - base) >= nbytes && !bus.busy && bus.empty) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, {63'd0, ok}, 64'd1);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic          we;
        logic [7:0]    wd;
        logic          dn;
        logic          gb;     // row ends in GAP when the gap feature is built
        logic [CW-1:0] e_cnt;
        logic          e_full;
        logic          e_empty;
        logic          e_ovf;
        logic          e_nd;
        logic [7:0]    e_dtx;
        logic          e_busy;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int          base;
        int          n;
        logic        eb;
        logic [17:0] exp_v;
        logic [7:0]  exp_b;

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;

        //             we    wd     dn    gb    cnt   full  empty ovf   nd    dintx  busy
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
        tbl[10] = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
        tbl[11] = '{1'b1, 8'h22, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0};

        // ---------------- reset state ----------------
        do_reset();
        check("reset_state", {46'd0, outs()}, {46'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});

        // ---------------- table ----------------
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].we, tbl[i].wd, tbl[i].dn);
            eb    = tbl[i].e_busy | (GAP_EN & tbl[i].gb);
            exp_v = {tbl[i].e_cnt, tbl[i].e_full, tbl[i].e_empty, tbl[i].e_ovf,
                     tbl[i].e_nd, tbl[i].e_dtx, eb};
            check($sformatf("vec%0d", i), {46'd0, outs()}, {46'd0, exp_v});
            if (GAP_EN && tbl[i].gb) idle(GAP);
        end

        // ---------------- burst 01..05 through the transmitter loop ----------------
        do_reset();
        tx_auto = 1'b1;
        base    = cap.size();
        for (int i = 1; i <= 5; i++) apply(1'b1, 8'(i), 1'b0);
        apply(1'b0, 8'h00, 1'b0);
        wait_drain("burst", base, 5, 3000);
        check("burst_count", 64'(cap.size() - base), 64'd5);
        for (int i = 0; i < 5; i++) begin
            exp_b = 8'(i + 1);
            check($sformatf("burst_byte%0d", i), {56'd0, cap[base + i]}, {56'd0, exp_b});
        end
        tx_auto = 1'b0;
        idle(2);

        // ---------------- overflow with stalled transmitter ----------------
        do_reset();
        base = cap.size();
        apply(1'b1, 8'h80, 1'b0);          // goes in flight, transmitter stalls
        apply(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            apply(1'b1, 8'(8'h40 + i), 1'b0);
            if (i == DEPTH - 1) begin
                check("ovf_full_at_depth", {62'd0, bus.full, bus.overflow}, {62'd0, 1'b1, 1'b0});
                check("ovf_count_at_depth", 64'(bus.count), 64'(DEPTH));
            end
        end
        apply(1'b0, 8'h00, 1'b0);
        check("ovf_sticky_set", {62'd0, bus.overflow, bus.full}, {62'd0, 1'b1, 1'b1});
        check("ovf_count_capped", 64'(bus.count), 64'(DEPTH));
        tx_auto = 1'b1;
        apply(1'b0, 8'h00, 1'b1);          // release the stalled first byte
        apply(1'b0, 8'h00, 1'b0);
        wait_drain("ovf_drain", base, DEPTH + 1, 8000);
        check("ovf_tx_count", 64'(cap.size() - base), 64'(DEPTH + 1));
        check("ovf_first_byte", {56'd0, cap[base]}, {56'd0, 8'h80});
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = 8'(8'h40 + i);
            check($sformatf("ovf_byte%0d", i), {56'd0, cap[base + 1 + i]}, {56'd0, exp_b});
        end
        check("ovf_still_sticky", {63'd0, bus.overflow}, 64'd1);
        tx_auto = 1'b0;
        idle(2);

        // ---------------- reset mid-byte with 3 queued ----------------
        for (int i = 0; i < 4; i++) apply(1'b1, 8'(8'hA1 + i), 1'b0);
        idle(2);
        check("mid_pre_count", {59'd0, bus.count, bus.busy}, {59'd0, 5'd3, 1'b1});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_state", {46'd0, outs()}, {46'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
        @(negedge clk);
        rst  = 1'b0;
        base = cap.size();
        apply(1'b0, 8'h00, 1'b1);          // stale completion after reset
        idle(30);
        check("mid_no_launch", 64'(cap.size() - base), 64'd0);
        check("mid_idle", {62'd0, bus.busy, bus.empty}, {62'd0, 1'b0, 1'b1});

        // ---------------- turnaround after donetx ----------------
        do_reset();
        apply(1'b1, 8'hB1, 1'b0);
        apply(1'b1, 8'hB2, 1'b0);          // B1 launches at this edge
        idle(3);
        @(negedge clk);
        done_man = 1'b1;
        @(posedge clk);                    // edge j: donetx sampled
        #1;
        @(negedge clk);
        done_man = 1'b0;
        n = 0;
        while (n < 500) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.newdata) break;
        end
`ifdef UART_TXQ_GAP_EN
        check("turnaround_min", {63'd0, (n >= GAP + 1) && (n < 500)}, 64'd1);
`else
        check("turnaround", 64'(n), 64'd1);
`endif
        check("turnaround_byte", {56'd0, bus.dintx}, {56'd0, 8'hB2});
        apply(1'b0, 8'h00, 1'b1);
        idle(GAP + 4);

        check("newdata_width", 64'(nd_double), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
